// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplies use 32 shift-add steps and divides use 32 restoring-subtract
// steps, both on operand magnitudes with a sign fix-up at the end. Divide by
// zero and signed overflow skip the iteration through a one-cycle FAST state.
//
// Handshake: start is sampled only on an edge where busy=0. busy stays high
// from the accepting edge until the edge that leaves FINISH. done is a single
// cycle pulse; reg_wr_dat, rd and regWrite are valid while done=1, and
// reg_wr_dat/rd hold their last values at all other times.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_dat,
    input  logic [31:0] rs2_dat,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] reg_wr_dat,
    output logic        regWrite,
    output logic [4:0]  rd,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FAST   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [4:0]  rd_lat;
    logic [31:0] opb;      // multiplicand for multiply, divisor for divide
    logic [63:0] acc;      // product, or {remainder, quotient} for divide
    logic [4:0]  count;
    logic        neg_q;    // result must be negated at the end
    logic        fast_q;   // acc[31:0] already holds the final result

    assign dbg_state = state;

    // Operand decode: signedness, magnitudes and special divide cases.
    logic        sa, sb, is_div, div_zero, div_ovf, neg_start;
    logic [31:0] mag_a, mag_b, fast_val;
    always_comb begin
        is_div    = funct3[2];
        sa        = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
        sb        = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        mag_a     = (sa && rs1_dat[31]) ? (32'd0 - rs1_dat) : rs1_dat;
        mag_b     = (sb && rs2_dat[31]) ? (32'd0 - rs2_dat) : rs2_dat;
        div_zero  = is_div && (rs2_dat == 32'd0);
        div_ovf   = is_div && !funct3[0] && (rs1_dat == 32'h8000_0000) &&
                    (rs2_dat == 32'hFFFF_FFFF);
        neg_start = 1'b0;
        case (funct3)
            3'b001, 3'b100: neg_start = rs1_dat[31] ^ rs2_dat[31];
            3'b010, 3'b110: neg_start = rs1_dat[31];
            default:        neg_start = 1'b0;
        endcase
        fast_val = 32'd0;
        if (div_zero)
            fast_val = funct3[1] ? rs1_dat : 32'hFFFF_FFFF;
        else if (div_ovf)
            fast_val = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    logic [32:0] mul_sum;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] acc_step;
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
        div_ge   = acc[63:31] >= {1'b0, opb};
        div_sub  = acc[62:31] - opb;
        acc_step = {mul_sum, acc[31:1]};
        if (op_q[2]) begin
            if (div_ge)
                acc_step = {div_sub, acc[30:0], 1'b1};
            else
                acc_step = {acc[62:0], 1'b0};
        end
    end

    // Final result selection with sign fix-up.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, result;
    always_comb begin
        prod_fix = neg_q ? (64'd0 - acc) : acc;
        quo_fix  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_fix  = neg_q ? (32'd0 - acc[63:32]) : acc[63:32];
        case (op_q)
            3'b000:         result = acc[31:0];
            3'b001, 3'b010: result = prod_fix[63:32];
            3'b011:         result = acc[63:32];
            3'b100, 3'b101: result = quo_fix;
            default:        result = rem_fix;
        endcase
        if (fast_q)
            result = acc[31:0];
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            regWrite   <= 1'b0;
            reg_wr_dat <= 32'd0;
            rd         <= 5'd0;
            count      <= 5'd0;
            op_q       <= 3'd0;
            rd_lat     <= 5'd0;
            opb        <= 32'd0;
            acc        <= 64'd0;
            neg_q      <= 1'b0;
            fast_q     <= 1'b0;
        end else begin
            done     <= 1'b0;
            regWrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= funct3;
                        rd_lat <= rd_in;
                        neg_q  <= neg_start;
                        busy   <= 1'b1;
                        count  <= 5'd0;
                        if (div_zero || div_ovf) begin
                            acc    <= {32'd0, fast_val};
                            opb    <= 32'd0;
                            fast_q <= 1'b1;
                            state  <= FAST;
                        end else begin
                            fast_q <= 1'b0;
                            acc    <= is_div ? {32'd0, mag_a} : {32'd0, mag_b};
                            opb    <= is_div ? mag_b : mag_a;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    count <= count + 5'd1;
                    if (count == 5'd31)
                        state <= FINISH;
                end
                FAST: begin
                    state <= FINISH;
                end
                FINISH: begin
                    reg_wr_dat <= result;
                    rd         <= rd_lat;
                    done       <= 1'b1;
                    regWrite   <= (rd_lat != 5'd0);
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_dat;
    logic [31:0] rs2_dat;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] reg_wr_dat;
    logic        regWrite;
    logic [4:0]  rd;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .funct3     (funct3),
        .rs1_dat    (rs1_dat),
        .rs2_dat    (rs2_dat),
        .rd_in      (rd_in),
        .busy       (busy),
        .done       (done),
        .reg_wr_dat (reg_wr_dat),
        .regWrite   (regWrite),
        .rd         (rd),
        .dbg_state  (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, optionally poke start during busy, and check latency/result.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input int lat,
                          input logic [31:0] exp_val, input bit inject);
        int k;
        @(negedge clk);
        start   = 1'b1;
        funct3  = f;
        rs1_dat = a;
        rs2_dat = b;
        rd_in   = r;
        @(negedge clk);
        start   = 1'b0;
        rs1_dat = $urandom;
        rs2_dat = $urandom;
        rd_in   = 5'($urandom_range(0, 31));
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) break;
            if (inject && k == 5) begin
                start   = 1'b1;
                funct3  = 3'b101;
                rs1_dat = 32'd1000;
                rs2_dat = 32'd0;
                rd_in   = 5'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(k), 32'(lat));
        check({tag, "_result"}, reg_wr_dat, exp_val);
        check({tag, "_regwrite"}, {31'd0, regWrite}, {31'd0, (r != 5'd0)});
        check({tag, "_rd"}, {27'd0, rd}, {27'd0, r});
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, reg_wr_dat, exp_val);
    endtask

    initial begin
        int dones;
        reset   = 1'b0;
        start   = 1'b0;
        funct3  = 3'd0;
        rs1_dat = 32'd0;
        rs2_dat = 32'd0;
        rd_in   = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_regwrite", {31'd0, regWrite}, 32'd0);
        check("rst_data", reg_wr_dat, 32'd0);
        check("rst_rd", {27'd0, rd}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b1;

        run_op("mul",      3'b000, 32'd5,         32'd10,        5'd3,  33, 32'd50,        1'b0);
        run_op("mulh",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  33, 32'h0000_0000, 1'b0);
        run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  33, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  33, 32'hFFFF_FFFF, 1'b0);
        run_op("mulh_neg", 3'b001, 32'hFFFF_FFFE, 32'd3,         5'd7,  33, 32'hFFFF_FFFF, 1'b0);
        run_op("div",      3'b100, 32'hFFFF_FFEC, 32'd3,         5'd8,  33, 32'hFFFF_FFFA, 1'b0);
        run_op("rem",      3'b110, 32'hFFFF_FFEC, 32'd3,         5'd9,  33, 32'hFFFF_FFFE, 1'b0);
        run_op("divu",     3'b101, 32'd20,        32'd3,         5'd10, 33, 32'd6,         1'b0);
        run_op("remu",     3'b111, 32'd100,       32'd7,         5'd31, 33, 32'd2,         1'b0);
        run_op("div_zero", 3'b100, 32'd20,        32'd0,         5'd11, 2,  32'hFFFF_FFFF, 1'b0);
        run_op("remu_zero",3'b111, 32'd20,        32'd0,         5'd12, 2,  32'd20,        1'b0);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 2,  32'h8000_0000, 1'b0);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 2,  32'd0,         1'b0);
        run_op("mul_rd0",  3'b000, 32'd7,         32'd6,         5'd0,  33, 32'd42,        1'b1);

        // Asynchronous reset in the middle of a DIVU.
        @(negedge clk);
        start   = 1'b1;
        funct3  = 3'b101;
        rs1_dat = 32'd20;
        rs2_dat = 32'd3;
        rd_in   = 5'd5;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_regwrite", {31'd0, regWrite}, 32'd0);
        check("arst_state", {30'd0, dbg_state}, 32'd0);
        check("arst_data", reg_wr_dat, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("arst_no_writeback", 32'(dones), 32'd0);
        run_op("divu_after_rst", 3'b101, 32'd20, 32'd3, 5'd5, 33, 32'd6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits (RV32M).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; block held in reset while reset=0.
REQ-004 start  input  1  request, sampled only when busy=0.
REQ-005 funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_dat  input  32  operand A, taken from register file read port rd1.
REQ-007 rs2_dat  input  32  operand B, taken from register file read port rd2.
REQ-008 rd_in  input  5  destination register index.
REQ-009 busy  output  1  operation in progress; start is ignored while high.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 reg_wr_dat  output  32  result, valid while done=1; drives register file write data.
REQ-012 regWrite  output  1  register file write enable; equals done AND (rd != 0).
REQ-013 rd  output  5  latched destination index, valid while done=1.

Function
REQ-014 States SHALL be IDLE, CALC, FAST and FINISH.
REQ-015 IDLE with start=1 at edge E0: the block SHALL latch funct3, both operands and rd_in, set busy=1, and go to CALC (or FAST per REQ-019).
REQ-016 CALC SHALL run a 5-bit counter for exactly 32 cycles: one shift-add step per cycle for multiply, one restoring-subtract step per cycle for divide.
REQ-017 After the 32nd CALC cycle the block SHALL enter FINISH; done=1 for exactly the cycle following edge E0+33, then IDLE with busy=0.
REQ-018 busy SHALL be 1 from edge E0 until the edge that leaves FINISH; a new start is accepted on the first edge at which busy=0 (back-to-back issue every 34 cycles).
REQ-019 Division with rs2=0, or signed DIV/REM with 0x80000000 / 0xFFFFFFFF, SHALL go to FAST (1 cycle) and then FINISH, giving done after edge E0+2.
REQ-020 Divide-by-zero: DIV/DIVU result SHALL be 0xFFFFFFFF and REM/REMU result SHALL be rs1.
REQ-021 Signed overflow: DIV result SHALL be 0x80000000 and REM result SHALL be 0.
REQ-022 Signed ops: operands SHALL be converted to magnitudes before iterating; the quotient is negated when operand signs differ; the remainder takes the sign of the dividend.
REQ-023 MULHSU SHALL treat rs1 as signed and rs2 as unsigned.
REQ-024 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32] of the 64-bit product.
REQ-025 With rd_in=0 the full latency SHALL still elapse and done SHALL still pulse, with regWrite=0.
REQ-026 reg_wr_dat and rd SHALL hold their last values outside done; the checker only samples them during done.
REQ-027 start=1 while busy=1 SHALL be ignored with no side effect on the operation in flight.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for clk, force: state IDLE, busy=0, done=0, regWrite=0, reg_wr_dat=0, rd=0, and counter=0.
REQ-029 Reset asserted mid-operation SHALL abort it with no write-back; the first start after reset release is accepted normally.
REQ-030 After reset deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-031 MUL rs1=5, rs2=10, rd_in=3 -> done at E0+33, reg_wr_dat=50, regWrite=1, rd=3.
REQ-032 MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000; MULHU with the same operands -> 0xFFFFFFFE; MULHSU with the same operands -> 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFEC (-20) / 3 -> 0xFFFFFFFA; REM with the same operands -> 0xFFFFFFFE; DIVU 20/3 -> 6; each completes at E0+33.
REQ-034 DIV 20/0 -> 0xFFFFFFFF and REMU 20/0 -> 20, each at E0+2; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at E0+2.
REQ-035 MUL with rd_in=0 -> done pulses and regWrite stays 0; start pulsed at E0+5 during busy -> ignored, result unchanged.
REQ-036 reset=0 asynchronously at E0+10 of a DIVU -> busy/done/regWrite drop immediately; no write-back occurs; the next op completes correctly.
